lsd_segment_arbiter: RTL and testbench
======================================

LSD_SEGMENT_ARBITER -- requirements
Module: lsd_segment_arbiter

Interface
REQ-001 SHALL have parameter V_WIDTH, default 10, bit width of vertical coordinates.
REQ-002 SHALL have parameter H_WIDTH, default 10, bit width of horizontal coordinates.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per requester FIFO (power of two, at least 2).
REQ-004 SHALL have parameter MAX_SEG, default 64, segments accepted per frame across both requesters.
REQ-005 SHALL have port clock, input, 1, the single clock (pixel clock); all logic is on its rising edge.
REQ-006 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_frame_start, input, 1, one-cycle pulse at vcnt==0 and hcnt==0.
REQ-008 SHALL have ports in_flag_i / in_valid_i, input, 1 each, for i in {0,1}; together they form the segment strobe from lsd_i.
REQ-009 SHALL have ports in_angle_i, input, 8; in_start_v_i / in_end_v_i, input, V_WIDTH; in_start_h_i / in_end_h_i, input, H_WIDTH.
REQ-010 SHALL have ports out_valid, output, 1; out_ready, input, 1; together they form the downstream handshake.
REQ-011 SHALL have ports out_src, output, 1 (requester id); out_angle, output, 8; out_start_v / out_end_v, output, V_WIDTH; out_start_h / out_end_h, output, H_WIDTH.
REQ-012 SHALL have port out_frame_drops, output, 8, drops counted in the previous frame.

Function
REQ-013 SHALL push the segment record from requester i into FIFO i on any cycle where in_flag_i and in_valid_i are both high.
REQ-014 SHALL drop a push if FIFO i is full with no same-cycle pop; a simultaneous push and pop on a full FIFO SHALL keep both operations.
REQ-015 SHALL drop a push if the per-frame accepted count equals MAX_SEG.
- If both requesters push in one cycle with one budget slot left, requester 0 SHALL win and requester 1 SHALL be dropped.
REQ-016 SHALL increment an internal drop counter for each dropped push, +2 when both requesters are dropped in one cycle, saturating at 255.
REQ-017 SHALL arbitrate round-robin between non-empty FIFOs when the output register is empty or is being accepted this cycle.
- A pointer SHALL record the last granted requester; it updates only on a grant.
- After reset the pointer SHALL favour requester 0.
REQ-018 SHALL register the output.
- Minimum latency is a strobe at edge k, then out_valid high after edge k+1.
- Throughput is one segment per cycle while out_ready stays high.
REQ-019 SHALL hold out_valid and all out_* data stable while out_valid is high and out_ready is low.
- Transfer occurs on an edge where both are high.
REQ-020 SHALL do the following on in_frame_start:
- Flush both FIFOs.
- Clear the accepted count.
- Copy the drop counter to out_frame_drops, then clear it.
- Reset the round-robin pointer.
- Leave a pending output transfer untouched.
REQ-021 SHALL treat a strobe coinciding with in_frame_start as belonging to the new frame.
- It is written after the flush and counted as 1.
REQ-022 SHALL block the FIFO-to-output grant in the frame_start cycle, so no pre-flush entry leaks out.

Reset
REQ-023 SHALL, while n_rst is low, clear all of the following asynchronously:
- FIFO pointers and occupancy.
- Counters and the round-robin pointer.
- out_valid.
- All out_* data and out_frame_drops, which SHALL read 0.
REQ-024 SHALL, on reset mid-transfer, discard all pending segments; the first valid output follows the first strobe after n_rst deasserts.

Structure
REQ-025 SHALL take the following from shared package lsd_pkg, used by simple_lsd consumers:
- The segment record typedef (angle, start_v, start_h, end_v, end_h).
- Default widths.
- Record width 8+2*V_WIDTH+2*H_WIDTH.
REQ-026 SHALL instantiate sub-module lsd_seg_fifo twice.
- Each instance is a synchronous FIFO with full, empty, count and a flush input.
- Arbitration, budget and counters SHALL live in the top module.

Verification
REQ-027 SHALL verify a single strobe on requester 0 at cycle 10 with out_ready=1: out_valid high at cycle 12 for one cycle, out_src=0, data equal to the input.
REQ-028 SHALL verify that both requesters strobing every cycle for 4 cycles with out_ready=1 produce output sources 0,1,0,1,0,1,0,1 with no drops.
REQ-029 SHALL verify that with out_ready=0 and 10 strobes on requester 0 (FIFO_DEPTH=8):
- out_valid holds the first record stable.
- One record sits in the output register and 8 in the FIFO.
- 1 drop occurs.
- out_frame_drops=1 after the next in_frame_start.
REQ-030 SHALL verify that with MAX_SEG=4 and 6 single strobes in one frame, 4 records are delivered and out_frame_drops=2 after the next frame start.
REQ-031 SHALL verify that in_frame_start with 3 entries queued and out_ready=0:
- The held record is delivered.
- The queued entries never appear.
- A strobe coincident with frame_start is delivered next.
REQ-032 SHALL verify that asserting n_rst low mid-stream clears out_valid within the same cycle, and no stale record appears after release.

Source files
------------

// File: rtl/lsd_pkg.sv
// Shared segment definitions for simple_lsd consumers.
// Contents: default coordinate widths, the segment record layout, and a helper
// that returns the packed record width for arbitrary coordinate widths.
package lsd_pkg;

  localparam int unsigned DefVWidth  = 10;
  localparam int unsigned DefHWidth  = 10;
  localparam int unsigned AngleWidth = 8;

  // Packed width of one segment record: angle + two vertical + two horizontal coordinates.
  function automatic int unsigned seg_rec_width(int unsigned v_width, int unsigned h_width);
    return AngleWidth + 2 * v_width + 2 * h_width;
  endfunction

  // Record at default widths; field order is the packing order used everywhere.
  typedef struct packed {
    logic [AngleWidth-1:0] angle;
    logic [DefVWidth-1:0]  start_v;
    logic [DefHWidth-1:0]  start_h;
    logic [DefVWidth-1:0]  end_v;
    logic [DefHWidth-1:0]  end_h;
  } seg_rec_t;

  localparam int unsigned SegRecWidth = seg_rec_width(DefVWidth, DefHWidth);

endpackage

// File: rtl/lsd_seg_fifo.sv
// Synchronous FIFO holding segment records for one requester.
// Ports:
//   clock, n_rst    - clock and asynchronous active-low reset
//   flush           - empties the FIFO; a same-cycle push lands in the emptied FIFO
//   push, wdata     - write strobe and record
//   pop, rdata      - read strobe and head record (rdata valid while !empty)
//   full, empty     - occupancy flags
//   count           - number of stored entries
// The caller only pushes when !full (or full with a same-cycle pop) and only pops when !empty.
module lsd_seg_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [PtrW-1:0]  wr_addr;

  // After a flush the write pointer restarts at slot 0.
  assign wr_addr = flush ? '0 : wr_ptr_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push ? PtrW'(1) : '0;
      count_q  <= push ? CntW'(1) : '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clock) begin
    if (push) mem[wr_addr] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/lsd_segment_arbiter.sv
// Merges segment strobes from two line-segment detectors into one registered
// valid/ready stream, with per-requester FIFOs, a per-frame segment budget and
// a per-frame drop counter.
// Ports:
//   clock, n_rst                 - pixel clock, asynchronous active-low reset
//   in_frame_start               - one-cycle pulse at the first pixel of a frame
//   in_flag_i / in_valid_i       - segment strobe from requester i (both high = push)
//   in_angle_i, in_start_v_i, in_end_v_i, in_start_h_i, in_end_h_i - segment record i
//   out_valid / out_ready        - downstream handshake
//   out_src, out_angle, out_start_v, out_end_v, out_start_h, out_end_h - output record
//   out_frame_drops              - drops counted during the previous frame
module lsd_segment_arbiter
  import lsd_pkg::*;
#(
  parameter int unsigned V_WIDTH    = DefVWidth,
  parameter int unsigned H_WIDTH    = DefHWidth,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_SEG    = 64
) (
  input  logic               clock,
  input  logic               n_rst,
  input  logic               in_frame_start,
  input  logic               in_flag_0,
  input  logic               in_valid_0,
  input  logic [7:0]         in_angle_0,
  input  logic [V_WIDTH-1:0] in_start_v_0,
  input  logic [V_WIDTH-1:0] in_end_v_0,
  input  logic [H_WIDTH-1:0] in_start_h_0,
  input  logic [H_WIDTH-1:0] in_end_h_0,
  input  logic               in_flag_1,
  input  logic               in_valid_1,
  input  logic [7:0]         in_angle_1,
  input  logic [V_WIDTH-1:0] in_start_v_1,
  input  logic [V_WIDTH-1:0] in_end_v_1,
  input  logic [H_WIDTH-1:0] in_start_h_1,
  input  logic [H_WIDTH-1:0] in_end_h_1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_src,
  output logic [7:0]         out_angle,
  output logic [V_WIDTH-1:0] out_start_v,
  output logic [V_WIDTH-1:0] out_end_v,
  output logic [H_WIDTH-1:0] out_start_h,
  output logic [H_WIDTH-1:0] out_end_h,
  output logic [7:0]         out_frame_drops
);

  localparam int unsigned RecWidth = seg_rec_width(V_WIDTH, H_WIDTH);
  localparam int unsigned CntW     = $clog2(MAX_SEG + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  // Same layout as lsd_pkg::seg_rec_t, at this instance's widths.
  typedef struct packed {
    logic [AngleWidth-1:0] angle;
    logic [V_WIDTH-1:0]    start_v;
    logic [H_WIDTH-1:0]    start_h;
    logic [V_WIDTH-1:0]    end_v;
    logic [H_WIDTH-1:0]    end_h;
  } rec_t;

  rec_t wr_rec_0, wr_rec_1, rd_rec_0, rd_rec_1, sel_rec;

  logic strobe_0, strobe_1;
  logic accept_0, accept_1;
  logic pop_0, pop_1;
  logic full_0, full_1, empty_0, empty_1;
  logic [FifoCntW-1:0] count_0, count_1;
  logic unused_count;

  logic            load;
  logic            grant;
  logic            prio_q;      // requester preferred on the next contested grant
  logic [CntW-1:0] seg_cnt_q, seg_cnt_base, seg_cnt_d, room;
  logic [7:0]      drop_q, drop_base, drop_d;
  logic [8:0]      drop_sum;
  logic [1:0]      drops_now;

  logic               out_valid_q, out_src_q;
  rec_t               out_rec_q;
  logic [7:0]         frame_drops_q;

  assign unused_count = ^{count_0, count_1};

  assign strobe_0 = in_flag_0 & in_valid_0;
  assign strobe_1 = in_flag_1 & in_valid_1;

  assign wr_rec_0 = '{angle: in_angle_0, start_v: in_start_v_0, start_h: in_start_h_0,
                      end_v: in_end_v_0, end_h: in_end_h_0};
  assign wr_rec_1 = '{angle: in_angle_1, start_v: in_start_v_1, start_h: in_start_h_1,
                      end_v: in_end_v_1, end_h: in_end_h_1};

  // Grant: never during frame start so flushed entries cannot leak out.
  always_comb begin
    load  = (~out_valid_q | out_ready) & ~in_frame_start & ~(empty_0 & empty_1);
    grant = (!empty_0 && !empty_1) ? prio_q : empty_0;
    pop_0 = load & ~grant;
    pop_1 = load & grant;
    sel_rec = grant ? rd_rec_1 : rd_rec_0;
  end

  // Admission: a frame-start strobe is judged against the freshly cleared frame.
  always_comb begin
    seg_cnt_base = in_frame_start ? '0 : seg_cnt_q;
    room         = CntW'(MAX_SEG) - seg_cnt_base;
    accept_0     = strobe_0 & (in_frame_start | ~full_0 | pop_0) & (room != '0);
    accept_1     = strobe_1 & (in_frame_start | ~full_1 | pop_1) & (room > CntW'(accept_0));
    seg_cnt_d    = seg_cnt_base + CntW'(accept_0) + CntW'(accept_1);
    drops_now    = 2'(strobe_0 & ~accept_0) + 2'(strobe_1 & ~accept_1);
    drop_base    = in_frame_start ? '0 : drop_q;
    drop_sum     = {1'b0, drop_base} + 9'(drops_now);
    drop_d       = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  lsd_seg_fifo #(
    .WIDTH (RecWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_0 (
    .clock (clock),
    .n_rst (n_rst),
    .flush (in_frame_start),
    .push  (accept_0),
    .wdata (wr_rec_0),
    .pop   (pop_0),
    .rdata (rd_rec_0),
    .full  (full_0),
    .empty (empty_0),
    .count (count_0)
  );

  lsd_seg_fifo #(
    .WIDTH (RecWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_1 (
    .clock (clock),
    .n_rst (n_rst),
    .flush (in_frame_start),
    .push  (accept_1),
    .wdata (wr_rec_1),
    .pop   (pop_1),
    .rdata (rd_rec_1),
    .full  (full_1),
    .empty (empty_1),
    .count (count_1)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      prio_q        <= 1'b0;
      seg_cnt_q     <= '0;
      drop_q        <= '0;
      frame_drops_q <= '0;
      out_valid_q   <= 1'b0;
      out_src_q     <= 1'b0;
      out_rec_q     <= '0;
    end else begin
      seg_cnt_q <= seg_cnt_d;
      drop_q    <= drop_d;
      if (in_frame_start) begin
        frame_drops_q <= drop_q;
        prio_q        <= 1'b0;
      end else if (load) begin
        prio_q <= ~grant;
      end
      // A pending output record is unaffected by frame start.
      if (load) begin
        out_valid_q <= 1'b1;
        out_src_q   <= grant;
        out_rec_q   <= sel_rec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_src         = out_src_q;
  assign out_angle       = out_rec_q.angle;
  assign out_start_v     = out_rec_q.start_v;
  assign out_end_v       = out_rec_q.end_v;
  assign out_start_h     = out_rec_q.start_h;
  assign out_end_h       = out_rec_q.end_h;
  assign out_frame_drops = frame_drops_q;

endmodule

// File: tb/tb_lsd_segment_arbiter.sv
module tb_lsd_segment_arbiter;

  logic       clock = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_frame_start = 1'b0;
  logic       in_flag_0 = 1'b0, in_valid_0 = 1'b0, in_flag_1 = 1'b0, in_valid_1 = 1'b0;
  logic [7:0] in_angle_0 = '0, in_angle_1 = '0;
  logic [9:0] in_start_v_0 = '0, in_end_v_0 = '0, in_start_h_0 = '0, in_end_h_0 = '0;
  logic [9:0] in_start_v_1 = '0, in_end_v_1 = '0, in_start_h_1 = '0, in_end_h_1 = '0;
  logic       out_ready = 1'b0;

  logic       out_valid, out_src;
  logic [7:0] out_angle, out_frame_drops;
  logic [9:0] out_start_v, out_end_v, out_start_h, out_end_h;

  logic       o4_valid, o4_src;
  logic [7:0] o4_angle, o4_frame_drops;
  logic [9:0] o4_start_v, o4_end_v, o4_start_h, o4_end_h;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int n4     = 0;
  logic       got_src[$];
  logic [7:0] got_ang[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (out_valid && out_ready) begin
      got_src.push_back(out_src);
      got_ang.push_back(out_angle);
    end
    if (o4_valid && out_ready) n4 <= n4 + 1;
  end

  lsd_segment_arbiter dut (
    .clock (clock), .n_rst (n_rst), .in_frame_start (in_frame_start),
    .in_flag_0 (in_flag_0), .in_valid_0 (in_valid_0), .in_angle_0 (in_angle_0),
    .in_start_v_0 (in_start_v_0), .in_end_v_0 (in_end_v_0),
    .in_start_h_0 (in_start_h_0), .in_end_h_0 (in_end_h_0),
    .in_flag_1 (in_flag_1), .in_valid_1 (in_valid_1), .in_angle_1 (in_angle_1),
    .in_start_v_1 (in_start_v_1), .in_end_v_1 (in_end_v_1),
    .in_start_h_1 (in_start_h_1), .in_end_h_1 (in_end_h_1),
    .out_valid (out_valid), .out_ready (out_ready), .out_src (out_src),
    .out_angle (out_angle), .out_start_v (out_start_v), .out_end_v (out_end_v),
    .out_start_h (out_start_h), .out_end_h (out_end_h),
    .out_frame_drops (out_frame_drops)
  );

  lsd_segment_arbiter #(.MAX_SEG (4)) dut4 (
    .clock (clock), .n_rst (n_rst), .in_frame_start (in_frame_start),
    .in_flag_0 (in_flag_0), .in_valid_0 (in_valid_0), .in_angle_0 (in_angle_0),
    .in_start_v_0 (in_start_v_0), .in_end_v_0 (in_end_v_0),
    .in_start_h_0 (in_start_h_0), .in_end_h_0 (in_end_h_0),
    .in_flag_1 (in_flag_1), .in_valid_1 (in_valid_1), .in_angle_1 (in_angle_1),
    .in_start_v_1 (in_start_v_1), .in_end_v_1 (in_end_v_1),
    .in_start_h_1 (in_start_h_1), .in_end_h_1 (in_end_h_1),
    .out_valid (o4_valid), .out_ready (out_ready), .out_src (o4_src),
    .out_angle (o4_angle), .out_start_v (o4_start_v), .out_end_v (o4_end_v),
    .out_start_h (o4_start_h), .out_end_h (o4_end_h),
    .out_frame_drops (o4_frame_drops)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Record for id: angle=id, start_v=id+100, start_h=id+300, end_v=id+200, end_h=id+400.
  task automatic set_req(input int r, input int id);
    if (r == 0) begin
      in_flag_0 = 1'b1; in_valid_0 = 1'b1; in_angle_0 = 8'(id);
      in_start_v_0 = 10'(id + 100); in_end_v_0 = 10'(id + 200);
      in_start_h_0 = 10'(id + 300); in_end_h_0 = 10'(id + 400);
    end else begin
      in_flag_1 = 1'b1; in_valid_1 = 1'b1; in_angle_1 = 8'(id);
      in_start_v_1 = 10'(id + 100); in_end_v_1 = 10'(id + 200);
      in_start_h_1 = 10'(id + 300); in_end_h_1 = 10'(id + 400);
    end
  endtask

  task automatic clear_reqs();
    in_flag_0 = 1'b0; in_valid_0 = 1'b0; in_flag_1 = 1'b0; in_valid_1 = 1'b0;
  endtask

  task automatic pulse_fs();
    in_frame_start = 1'b1;
    tick();
    in_frame_start = 1'b0;
  endtask

  task automatic clear_mon();
    got_src.delete();
    got_ang.delete();
    n4 = 0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    ticks(2);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %0b want 0", out_valid); fails++;
    end
    checks++;
    if ({out_src, out_angle, out_start_v, out_end_v, out_start_h, out_end_h} !== '0) begin
      $display("FAIL reset_data: got src=%0b ang=%0d sv=%0d want all 0", out_src, out_angle,
               out_start_v); fails++;
    end
    checks++;
    if (out_frame_drops !== 8'd0) begin
      $display("FAIL reset_drops: got %0d want 0", out_frame_drops); fails++;
    end
    n_rst = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_single();
    while (cyc < 10) tick();
    set_req(0, 55);
    tick();
    clear_reqs();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_early: got valid=%0b want 0", out_valid); fails++;
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0) begin
      $display("FAIL single_valid: got valid=%0b src=%0b want 1 0", out_valid, out_src); fails++;
    end
    checks++;
    if (out_angle !== 8'd55 || out_start_v !== 10'd155 || out_end_v !== 10'd255 ||
        out_start_h !== 10'd355 || out_end_h !== 10'd455) begin
      $display("FAIL single_data: got %0d %0d %0d %0d %0d want 55 155 255 355 455", out_angle,
               out_start_v, out_end_v, out_start_h, out_end_h); fails++;
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_once: got valid=%0b want 0", out_valid); fails++;
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_ang;
    out_ready = 1'b1;
    pulse_fs();
    clear_mon();
    for (int c = 0; c < 4; c++) begin
      set_req(0, 10 + c);
      set_req(1, 20 + c);
      tick();
    end
    clear_reqs();
    ticks(12);
    checks++;
    if (got_src.size() != 8) begin
      $display("FAIL alt_count: got %0d want 8", got_src.size()); fails++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_ang = (i % 2 == 0) ? 8'(10 + i / 2) : 8'(20 + i / 2);
        checks++;
        if (got_src[i] !== 1'(i % 2) || got_ang[i] !== exp_ang) begin
          $display("FAIL alt_seq[%0d]: got src=%0b ang=%0d want src=%0d ang=%0d", i,
                   got_src[i], got_ang[i], i % 2, exp_ang); fails++;
        end
      end
    end
    pulse_fs();
    checks++;
    if (out_frame_drops !== 8'd0) begin
      $display("FAIL alt_drops: got %0d want 0", out_frame_drops); fails++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pulse_fs();
    clear_mon();
    for (int i = 1; i <= 10; i++) begin
      set_req(0, i);
      tick();
    end
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_angle !== 8'd1 || out_start_v !== 10'd101) begin
        $display("FAIL bp_hold: got valid=%0b ang=%0d sv=%0d want 1 1 101", out_valid,
                 out_angle, out_start_v); fails++;
      end
    end
    out_ready = 1'b1;
    ticks(12);
    checks++;
    if (got_ang.size() != 9) begin
      $display("FAIL bp_count: got %0d want 9", got_ang.size()); fails++;
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got_ang[i] !== 8'(i + 1)) begin
          $display("FAIL bp_seq[%0d]: got %0d want %0d", i, got_ang[i], i + 1); fails++;
        end
      end
    end
    pulse_fs();
    checks++;
    if (out_frame_drops !== 8'd1) begin
      $display("FAIL bp_drops: got %0d want 1", out_frame_drops); fails++;
    end
  endtask

  task automatic test_budget();
    out_ready = 1'b1;
    pulse_fs();
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 40 + i);
      tick();
      clear_reqs();
      tick();
    end
    ticks(4);
    checks++;
    if (n4 != 4) begin
      $display("FAIL budget_delivered: got %0d want 4", n4); fails++;
    end
    checks++;
    if (got_ang.size() != 6) begin
      $display("FAIL budget_default_delivered: got %0d want 6", got_ang.size()); fails++;
    end
    pulse_fs();
    checks++;
    if (o4_frame_drops !== 8'd2) begin
      $display("FAIL budget_drops: got %0d want 2", o4_frame_drops); fails++;
    end
    checks++;
    if (out_frame_drops !== 8'd0) begin
      $display("FAIL budget_default_drops: got %0d want 0", out_frame_drops); fails++;
    end
  endtask

  task automatic test_frame_flush();
    out_ready = 1'b0;
    pulse_fs();
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 21 + i);
      tick();
    end
    clear_reqs();
    ticks(2);
    set_req(0, 30);
    in_frame_start = 1'b1;
    tick();
    in_frame_start = 1'b0;
    clear_reqs();
    ticks(2);
    checks++;
    if (out_valid !== 1'b1 || out_angle !== 8'd21) begin
      $display("FAIL flush_hold: got valid=%0b ang=%0d want 1 21", out_valid, out_angle); fails++;
    end
    checks++;
    if (out_frame_drops !== 8'd0) begin
      $display("FAIL flush_drops: got %0d want 0", out_frame_drops); fails++;
    end
    out_ready = 1'b1;
    ticks(8);
    checks++;
    if (got_ang.size() != 2) begin
      $display("FAIL flush_count: got %0d want 2", got_ang.size()); fails++;
    end else begin
      checks++;
      if (got_ang[0] !== 8'd21 || got_ang[1] !== 8'd30) begin
        $display("FAIL flush_seq: got %0d,%0d want 21,30", got_ang[0], got_ang[1]); fails++;
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    clear_mon();
    set_req(0, 60);
    tick();
    set_req(0, 61);
    tick();
    clear_reqs();
    ticks(2);
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL rstmid_pre: got valid=%0b want 1", out_valid); fails++;
    end
    #3;
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_angle !== 8'd0 || out_frame_drops !== 8'd0) begin
      $display("FAIL rstmid_async: got valid=%0b ang=%0d drops=%0d want 0 0 0", out_valid,
               out_angle, out_frame_drops); fails++;
    end
    ticks(2);
    n_rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL rstmid_stale[%0d]: got valid=%0b want 0", i, out_valid); fails++;
      end
    end
    set_req(1, 77);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_angle !== 8'd77) begin
      $display("FAIL rstmid_after: got valid=%0b src=%0b ang=%0d want 1 1 77", out_valid,
               out_src, out_angle); fails++;
    end
    tick();
    checks++;
    if (got_ang.size() != 1) begin
      $display("FAIL rstmid_total: got %0d want 1", got_ang.size()); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_budget();
    test_frame_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
